// File: rtl/fp_norm_round.sv
// fp_norm_round
// Post-multiply normalize / round / pack stage for the fp_multiplier datapath.
// Takes an unnormalized 32-bit mantissa plus the leading-zero count and valid
// bit from the upstream 32-bit LZC. It normalizes the mantissa, adjusts the
// exponent, rounds to nearest-even and packs an IEEE-754 single. The stage is
// a two-deep valid/ready pipeline that runs at full rate and is safe under
// backpressure.
//
// Optional build macro: FP_NORM_LZC_CHECK_EN
//   When defined, stage 1 recomputes the leading-zero count of in_mant and
//   sets the sticky lzc_err output on any accepted beat whose in_lz / in_lz_v
//   disagree with it. When undefined, lzc_err is tied to 0.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_sign             result sign
//   in_exp [EXP_W]      signed biased exponent of in_mant bit 31
//   in_mant[32]         unnormalized mantissa
//   in_lz  [5]          leading-zero count of in_mant
//   in_lz_v             1 = in_mant is non-zero
//   out_valid/out_ready output handshake
//   out_result[32]      packed IEEE single
//   out_flags[4]        {overflow, underflow, inexact, zero}
//   lzc_err             sticky LZC consistency error
module fp_norm_round #(
    parameter int EXP_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [31:0]      in_mant,
    input  logic [4:0]       in_lz,
    input  logic             in_lz_v,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [3:0]       out_flags,
    output logic             lzc_err
);

    localparam logic signed [EXP_W+1:0] EXP_MAX  = (EXP_W+2)'(255);
    localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;

    logic                    s1_valid;
    logic                    s1_sign;
    logic                    s1_nz;
    logic [30:0]             s1_norm;
    logic signed [EXP_W:0]   s1_exp;
    logic                    s2_valid;

    logic                    s1_adv;
    logic                    s1_load;
    logic [31:0]             norm;
    logic signed [EXP_W:0]   exp_n;

    // Stage 1 may advance whenever stage 2 is empty or draining; the input
    // side may then accept even with stage 1 full, so a full pipe keeps
    // streaming without a bubble.
    assign s1_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s1_adv;
    assign s1_load   = in_valid && in_ready;
    assign out_valid = s2_valid;

    // Bit 31 of the normalized mantissa is the implied one (in_lz is
    // trusted), so only bits 30:0 are carried into stage 1.
    assign norm  = in_mant << in_lz;
    assign exp_n = $signed({in_exp[EXP_W-1], in_exp}) - $signed({{(EXP_W-4){1'b0}}, in_lz});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_nz    <= 1'b0;
            s1_norm  <= '0;
            s1_exp   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_nz   <= in_lz_v;
                s1_norm <= norm[30:0];
                s1_exp  <= exp_n;
            end
        end
    end

    logic                    guard_bit;
    logic                    sticky_bit;
    logic                    round_up;
    logic [23:0]             frac_r;
    logic signed [EXP_W+1:0] exp_f;
    logic [31:0]             result_d;
    logic [3:0]              flags_d;

    // Round to nearest-even on the 23-bit fraction. A carry out of the
    // fraction leaves frac_r[22:0] all zero and bumps the exponent, so the
    // range checks below see the post-rounding exponent.
    always_comb begin
        guard_bit  = s1_norm[7];
        sticky_bit = |s1_norm[6:0];
        round_up   = guard_bit && (sticky_bit || s1_norm[8]);
        frac_r     = {1'b0, s1_norm[30:8]} + {23'b0, round_up};
        exp_f      = $signed({s1_exp[EXP_W], s1_exp}) + $signed({{(EXP_W+1){1'b0}}, frac_r[23]});

        result_d = {s1_sign, exp_f[7:0], frac_r[22:0]};
        flags_d  = {2'b00, guard_bit || sticky_bit, 1'b0};
        if (!s1_nz) begin
            result_d = {s1_sign, 31'b0};
            flags_d  = 4'b0001;
        end else if (exp_f >= EXP_MAX) begin
            result_d = {s1_sign, 8'hFF, 23'b0};
            flags_d  = 4'b1010;
        end else if (exp_f <= EXP_ZERO) begin
            result_d = {s1_sign, 31'b0};
            flags_d  = 4'b0110;
        end
    end

    // Output registers only load when stage 2 advances, which holds the
    // result stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= result_d;
                out_flags  <= flags_d;
            end
        end
    end

`ifdef FP_NORM_LZC_CHECK_EN
    logic [4:0] lz_calc;
    logic       lz_found;
    logic       lz_mismatch;
    logic       lzc_err_q;

    // Independent priority search for the first set bit from the MSB. The
    // count is only meaningful for a non-zero mantissa.
    always_comb begin
        lz_calc  = '0;
        lz_found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!lz_found && in_mant[i]) begin
                lz_calc  = 5'(31 - i);
                lz_found = 1'b1;
            end
        end
        lz_mismatch = (in_lz_v != lz_found) || (lz_found && (lz_calc != in_lz));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lzc_err_q <= 1'b0;
        end else if (s1_load && lz_mismatch) begin
            lzc_err_q <= 1'b1;
        end
    end

    assign lzc_err = lzc_err_q;
`else
    assign lzc_err = 1'b0;
`endif

endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round
// Self-checking bench for fp_norm_round. Directed cases carry literal
// expected values; random beats are checked against an arithmetic model of
// normalize / round-to-nearest-even / pack. Expected results ride in a queue
// in acceptance order and are popped as results are consumed.
module tb_fp_norm_round;

    localparam int EXP_W = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_sign = 1'b0;
    logic [EXP_W-1:0] in_exp = '0;
    logic [31:0]      in_mant = '0;
    logic [4:0]       in_lz = '0;
    logic             in_lz_v = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_result;
    logic [3:0]       out_flags;
    logic             lzc_err;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [35:0] exp_q[$];
    logic [35:0] pending_exp = '0;
    bit          rand_ready = 1'b0;

`ifdef FP_NORM_LZC_CHECK_EN
    localparam logic LZC_EXPECT = 1'b1;
`else
    localparam logic LZC_EXPECT = 1'b0;
`endif

    fp_norm_round #(.EXP_W(EXP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_lz     (in_lz),
        .in_lz_v   (in_lz_v),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_flags (out_flags),
        .lzc_err   (lzc_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    // Value-level model: the real significand mant*2^lz is rounded to 24
    // bits with ties to even, then range-checked; returns {flags, result}.
    function automatic logic [35:0] model(input logic sign, input int exp_in,
                                          input logic [31:0] mant, input int lz,
                                          input logic v);
        logic [63:0] wide;
        longint      q;
        longint      rem;
        int          e;
        logic        inexact;
        if (!v) return {4'b0001, sign, 31'b0};
        wide = {32'b0, mant} << lz;
        q    = longint'(wide[31:0]) / 256;
        rem  = longint'(wide[31:0]) % 256;
        e    = exp_in - lz;
        inexact = (rem != 0);
        if (rem > 128 || (rem == 128 && (q % 2) == 1)) q = q + 1;
        if (q == (longint'(1) << 24)) begin
            q = q / 2;
            e = e + 1;
        end
        if (e >= 255) return {4'b1010, sign, 8'hFF, 23'b0};
        if (e <= 0) return {4'b0110, sign, 31'b0};
        return {2'b00, inexact, 1'b0, sign, 8'(e), 23'(q)};
    endfunction

    function automatic int count_lz(input logic [31:0] m);
        for (int i = 31; i >= 0; i--) if (m[i]) return 31 - i;
        return 0;
    endfunction

    task automatic check_output(input string tag, input logic [35:0] obs, input logic [35:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: sample handshakes just after the negedge drive, score any
    // output transfer, then advance to the next negedge.
    task automatic cycle_step(output bit accepted);
        logic [35:0] e;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            n_vec++;
            assert (exp_q.size() > 0) else begin
                n_miss++;
                $error("[TB] FAIL extra_beat observed=%h expected=none", {out_flags, out_result});
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("result", {out_flags, out_result}, e);
            end
        end
        if (accepted) exp_q.push_back(pending_exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic sign, input int exp_in, input logic [31:0] mant,
                                  input int lz, input logic v, input logic [35:0] expv);
        bit acc = 1'b0;
        int budget = 0;
        in_sign = sign;
        in_exp = EXP_W'(exp_in);
        in_mant = mant;
        in_lz = 5'(lz);
        in_lz_v = v;
        in_valid = 1'b1;
        pending_exp = expv;
        while (!acc && budget < 100) begin
            cycle_step(acc);
            budget++;
        end
        n_vec++;
        assert (acc) else begin
            n_miss++;
            $error("[TB] FAIL accept_timeout observed=%0d expected=1", acc);
        end
    endtask

    task automatic drain();
        bit acc;
        int budget = 0;
        in_valid = 1'b0;
        rand_ready = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && budget < 100) begin
            cycle_step(acc);
            budget++;
        end
        repeat (3) cycle_step(acc);
        check_output("drain_empty", 36'(exp_q.size()), 36'd0);
    endtask

    initial begin
        bit          acc;
        logic [31:0] held;
        logic [31:0] m;
        int          e;
        int          lz;
        logic        s;
        logic        v;

        repeat (3) @(negedge clk);
        #1;
        check_output("rst_out_valid", 36'(out_valid), 36'd0);
        check_output("rst_result", {out_flags, out_result}, 36'd0);
        check_output("rst_lzc_err", 36'(lzc_err), 36'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Identity with explicit latency: valid must appear on the second edge.
        in_sign = 1'b0; in_exp = EXP_W'(127); in_mant = 32'h8000_0000;
        in_lz = 5'd0; in_lz_v = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check_output("id_in_ready", 36'(in_ready), 36'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_output("id_lat1", 36'(out_valid), 36'd0);
        @(negedge clk);
        #1;
        check_output("id_lat2", 36'(out_valid), 36'd1);
        check_output("id_result", {out_flags, out_result}, {4'b0000, 32'h3F80_0000});
        @(negedge clk);

        // Directed cases from the normalization / rounding / range rules.
        apply_stimulus(1'b0, 158, 32'h0000_0001, 31, 1'b1, {4'b0000, 32'h3F80_0000});
        apply_stimulus(1'b1, 158, 32'h0000_0001, 31, 1'b1, {4'b0000, 32'hBF80_0000});
        apply_stimulus(1'b0, 127, 32'hFFFF_FF80, 0, 1'b1, {4'b0010, 32'h4000_0000});
        apply_stimulus(1'b0, 127, 32'h8000_0080, 0, 1'b1, {4'b0010, 32'h3F80_0000});
        apply_stimulus(1'b0, 127, 32'h8000_0180, 0, 1'b1, {4'b0010, 32'h3F80_0002});
        apply_stimulus(1'b0, 255, 32'h8000_0000, 0, 1'b1, {4'b1010, 32'h7F80_0000});
        apply_stimulus(1'b0, 0, 32'h8000_0000, 0, 1'b1, {4'b0110, 32'h0000_0000});
        apply_stimulus(1'b1, -5, 32'h8000_0000, 0, 1'b1, {4'b0110, 32'h8000_0000});
        apply_stimulus(1'b1, 127, 32'h0000_0000, 0, 1'b0, {4'b0001, 32'h8000_0000});
        apply_stimulus(1'b0, 254, 32'hFFFF_FF80, 0, 1'b1, {4'b1010, 32'h7F80_0000});
        drain();

        // Backpressure: two beats fill the pipe, the third must wait.
        out_ready = 1'b0;
        apply_stimulus(1'b0, 127, 32'h8000_0000, 0, 1'b1, {4'b0000, 32'h3F80_0000});
        apply_stimulus(1'b0, 128, 32'h8000_0000, 0, 1'b1, {4'b0000, 32'h4000_0000});
        in_exp = EXP_W'(129); in_mant = 32'h8000_0000; in_lz = 5'd0; in_lz_v = 1'b1;
        in_sign = 1'b0; in_valid = 1'b1; pending_exp = {4'b0000, 32'h4080_0000};
        #1;
        check_output("bp_in_ready", 36'(in_ready), 36'd0);
        check_output("bp_out_valid", 36'(out_valid), 36'd1);
        held = out_result;
        cycle_step(acc);
        cycle_step(acc);
        check_output("bp_no_accept", 36'(acc), 36'd0);
        check_output("bp_held", {4'b0, out_result}, {4'b0, held});
        out_ready = 1'b1;
        apply_stimulus(1'b0, 129, 32'h8000_0000, 0, 1'b1, {4'b0000, 32'h4080_0000});
        drain();

        // Random beats against the model with random consumer stalls.
        rand_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            s = 1'($urandom_range(0, 1));
            e = int'($urandom_range(0, 340)) - 40;
            v = ($urandom_range(0, 15) != 0);
            if (v) begin
                m = $urandom >> $urandom_range(0, 31);
                if (m == 32'd0) m = 32'd1;
                lz = count_lz(m);
            end else begin
                m = 32'd0;
                lz = 0;
            end
            apply_stimulus(s, e, m, lz, v, model(s, e, m, lz, v));
        end
        drain();

        // Reset mid-stream drops everything in flight at once.
        out_ready = 1'b0;
        apply_stimulus(1'b0, 130, 32'h8000_0000, 0, 1'b1, {4'b0000, 32'h4100_0000});
        apply_stimulus(1'b0, 131, 32'h8000_0000, 0, 1'b1, {4'b0000, 32'h4180_0000});
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_valid", 36'(out_valid), 36'd0);
        check_output("mid_rst_result", {out_flags, out_result}, 36'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) cycle_step(acc);
        check_output("post_rst_empty", 36'(out_valid), 36'd0);

        // Inconsistent LZC count: sticky error only when the checker is built.
        apply_stimulus(1'b0, 127, 32'h8000_0000, 3, 1'b1, model(1'b0, 127, 32'h8000_0000, 3, 1'b1));
        drain();
        check_output("lzc_err_set", 36'(lzc_err), 36'(LZC_EXPECT));
        apply_stimulus(1'b0, 127, 32'h8000_0000, 0, 1'b1, {4'b0000, 32'h3F80_0000});
        drain();
        check_output("lzc_err_sticky", 36'(lzc_err), 36'(LZC_EXPECT));
        rst_n = 1'b0;
        #1;
        check_output("lzc_err_rst", 36'(lzc_err), 36'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
